// File: rtl/i2s_capture_ctrl_if.sv
// FIFO-side and memory-write-side signals of the I2S capture controller.
// master = the controller, slave = FIFO/memory fabric (or a testbench driving them).
interface i2s_capture_ctrl_if;
  logic        fifo_empty;
  logic        fifo_full;
  logic [31:0] fifo_rdata;
  logic        fifo_rd;
  logic        fifo_flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;

  modport master (
    input  fifo_empty, fifo_full, fifo_rdata, mem_ack,
    output fifo_rd, fifo_flush, mem_req, mem_addr, mem_wdata
  );

  modport slave (
    output fifo_empty, fifo_full, fifo_rdata, mem_ack,
    input  fifo_rd, fifo_flush, mem_req, mem_addr, mem_wdata
  );
endinterface

// File: rtl/i2s_capture_ctrl.sv
// Moves samples from the I2S receive FIFO to memory, one 32-bit write per word,
// optionally packing two 16-bit samples per word. Supports abort and overrun flagging.
module i2s_capture_ctrl #(
  parameter int AW = 4,
  parameter int LW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [31:0]    base_addr,
  input  logic [LW-1:0]  xfer_len,
  input  logic           pack16,
  output logic           i2s_en,
  output logic           busy,
  output logic           done,
  output logic           aborted,
  output logic           overrun,
  output logic [LW-1:0]  words_done,
  i2s_capture_ctrl_if.master bus
);

  if (AW < 1) begin : g_aw_chk
    $error("i2s_capture_ctrl: AW must be at least 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_WAIT, S_WRITE, S_DONE} state_e;

  localparam logic [LW-1:0] ONE = LW'(1);

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [15:0]   low_q, low_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] words_q, words_d;
  logic          phase_q, phase_d;
  logic          abort_pend_q, abort_pend_d;
  logic          aborted_q, aborted_d;
  logic          overrun_q, overrun_d;
  logic          pop;
  logic [LW-1:0] words_inc;

  assign words_inc = words_q + ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      low_q        <= '0;
      len_q        <= '0;
      words_q      <= '0;
      phase_q      <= 1'b0;
      abort_pend_q <= 1'b0;
      aborted_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      low_q        <= low_d;
      len_q        <= len_d;
      words_q      <= words_d;
      phase_q      <= phase_d;
      abort_pend_q <= abort_pend_d;
      aborted_q    <= aborted_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    low_d        = low_q;
    len_d        = len_q;
    words_d      = words_q;
    phase_d      = phase_q;
    abort_pend_d = abort_pend_q;
    aborted_d    = aborted_q;
    overrun_d    = overrun_q;
    pop          = 1'b0;

    if (state_q != S_IDLE && bus.fifo_full) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        // start beats a simultaneous abort; a bare abort here does nothing
        if (start) begin
          words_d      = '0;
          aborted_d    = 1'b0;
          overrun_d    = 1'b0;
          phase_d      = 1'b0;
          abort_pend_d = 1'b0;
          if (xfer_len != '0) begin
            addr_d  = base_addr & 32'hFFFF_FFFC;
            len_d   = xfer_len;
            state_d = S_FLUSH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FLUSH: begin
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
          phase_d   = 1'b0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
          phase_d   = 1'b0;
        end else if (!bus.fifo_empty) begin
          pop = 1'b1;
          if (!pack16) begin
            wdata_d = bus.fifo_rdata;
            state_d = S_WRITE;
          end else if (!phase_q) begin
            low_d   = bus.fifo_rdata[15:0];
            phase_d = 1'b1;
          end else begin
            wdata_d = {bus.fifo_rdata[15:0], low_q};
            phase_d = 1'b0;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        // an abort here only takes effect once the outstanding write is acked
        if (abort) abort_pend_d = 1'b1;
        if (bus.mem_ack) begin
          addr_d       = addr_q + 32'd4;
          words_d      = words_inc;
          abort_pend_d = 1'b0;
          if (abort_pend_q || abort) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
            phase_d   = 1'b0;
          end else if (words_inc == len_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.fifo_rd    = pop;
  assign bus.fifo_flush = (state_q == S_FLUSH);
  assign bus.mem_req    = (state_q == S_WRITE);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign i2s_en         = (state_q == S_FLUSH) || (state_q == S_WAIT) || (state_q == S_WRITE);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign aborted        = aborted_q;
  assign overrun        = overrun_q;
  assign words_done     = words_q;

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// Randomized scoreboard bench for i2s_capture_ctrl: FIFO/memory models, expected
// writes queued at stimulus time and checked by an independent monitor.
module tb_i2s_capture_ctrl;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst, start, abort, pack16;
  logic [31:0]   base_addr;
  logic [LW-1:0] xfer_len;
  logic          i2s_en, busy, done, aborted, overrun;
  logic [LW-1:0] words_done;

  i2s_capture_ctrl_if bus ();

  i2s_capture_ctrl #(.AW(4), .LW(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .xfer_len(xfer_len), .pack16(pack16),
    .i2s_en(i2s_en), .busy(busy), .done(done), .aborted(aborted),
    .overrun(overrun), .words_done(words_done), .bus(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] addr; logic [31:0] data;} wr_t;

  int          checks = 0, failures = 0;
  wr_t         exp_q[$];
  logic [31:0] fifo_q[$];
  bit          gap_en = 1'b0;
  bit          rd_seen = 1'b0;
  int          force_dly = -1;
  int          ack_target = 0, req_age = 0;
  logic [31:0] hold_addr, hold_data;
  wr_t         mon_e;
  int          done_cnt, flush_cnt, pop_cnt, req_cnt, en_cnt, wr_cnt;
  int          cyc = 0, done_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO model: head is popped after the edge that consumed it; random empty gaps
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
    rd_seen = 1'b0;
    bus.fifo_empty = (fifo_q.size() == 0) || (gap_en && $urandom_range(0, 3) == 0);
    bus.fifo_rdata = (fifo_q.size() > 0) ? fifo_q[0] : $urandom;
  end

  // Monitor and memory responder, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      bus.mem_ack = 1'b0;
      req_age = 0;
    end else begin
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (bus.fifo_flush) flush_cnt++;
      if (i2s_en) en_cnt++;
      if (bus.fifo_rd) begin
        pop_cnt++;
        rd_seen = 1'b1;
        chk("rd_with_req", bus.mem_req, 0);
        chk("rd_when_empty", bus.fifo_empty, 0);
      end
      if (bus.mem_req) begin
        req_cnt++;
        if (req_age == 0) begin
          ack_target = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 2));
          hold_addr = bus.mem_addr;
          hold_data = bus.mem_wdata;
        end else begin
          chk("addr_stable", bus.mem_addr, hold_addr);
          chk("data_stable", bus.mem_wdata, hold_data);
        end
        if (req_age == ack_target) begin
          bus.mem_ack = 1'b1;
          req_age = 0;
          wr_cnt++;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_write: addr %h data %h, no write expected", bus.mem_addr, bus.mem_wdata);
          end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", bus.mem_addr, mon_e.addr);
            chk("wr_data", bus.mem_wdata, mon_e.data);
          end
        end else begin
          bus.mem_ack = 1'b0;
          req_age++;
        end
      end else begin
        // stray acks outside a request must be ignored
        bus.mem_ack = ($urandom_range(0, 5) == 0);
        req_age = 0;
      end
    end
  end

  task automatic clr_counts();
    done_cnt = 0; flush_cnt = 0; pop_cnt = 0; req_cnt = 0; en_cnt = 0; wr_cnt = 0;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  // called at posedge+1; returns at posedge+1 of the cycle after start was sampled
  task automatic pulse_start(input logic [31:0] b, input int len, input bit p, input bit with_abort);
    base_addr = b; xfer_len = LW'(len); pack16 = p; start = 1'b1; abort = with_abort;
    next_cyc();
    start = 1'b0; abort = 1'b0;
    base_addr = $urandom; xfer_len = LW'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 3000);
    if (busy) begin
      checks++; failures++;
      $display("FAIL %s_timeout: busy=1 after %0d cycles, required 0", name, n);
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.mem_req && n < 200);
    if (!bus.mem_req) begin
      checks++; failures++;
      $display("FAIL %s_req_timeout: mem_req=0 after %0d cycles, required 1", name, n);
    end
  endtask

  task automatic load(input logic [31:0] b, input int len, input bit p, input bit fixed);
    logic [31:0] samp[$];
    wr_t e;
    int nsamp = p ? 2 * len : len;
    for (int i = 0; i < nsamp; i++) begin
      samp.push_back(fixed ? 32'h1111 * (i + 1) : $urandom);
      fifo_q.push_back(samp[i]);
    end
    for (int i = 0; i < len; i++) begin
      e.addr = (b & 32'hFFFF_FFFC) + 32'(4 * i);
      e.data = p ? {samp[2*i+1][15:0], samp[2*i][15:0]} : samp[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic run_capture(input string name, input logic [31:0] b, input int len,
                             input bit p, input bit fixed, input bit abort_too);
    int nsamp = p ? 2 * len : len;
    load(b, len, p, fixed);
    clr_counts();
    pulse_start(b, len, p, abort_too);
    next_cyc();
    start = 1'b1;          // still busy here, so this start must be ignored
    next_cyc();
    start = 1'b0;
    wait_idle(name);
    chk({name, "_words"}, words_done, len);
    chk({name, "_done"}, done_cnt, 1);
    chk({name, "_flush"}, flush_cnt, 1);
    chk({name, "_pops"}, pop_cnt, nsamp);
    chk({name, "_aborted"}, aborted, 0);
    chk({name, "_exp_left"}, exp_q.size(), 0);
    next_cyc();
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_ctrl"}, {i2s_en, busy, done, aborted, overrun, bus.mem_req, bus.fifo_rd, bus.fifo_flush}, 0);
    chk({name, "_words"}, words_done, 0);
    chk({name, "_addr"}, bus.mem_addr, 0);
    chk({name, "_wdata"}, bus.mem_wdata, 0);
  endtask

  initial begin
    int st, d;
    rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; xfer_len = '0; pack16 = 1'b0;
    bus.fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");
    next_cyc();

    // three plain words with prompt acks
    force_dly = 0;
    run_capture("basic", 32'h1000, 3, 1'b0, 1'b0, 1'b0);
    // two packed words from 1111/2222/3333/4444
    run_capture("pack", 32'h2000, 2, 1'b1, 1'b1, 1'b0);
    force_dly = -1;

    // zero length: done only, no bus activity
    clr_counts();
    st = cyc;
    pulse_start(32'h2400, 0, 1'b0, 1'b0);
    wait_idle("zero");
    d = done_cyc - st;
    chk("zero_done", done_cnt, 1);
    chk("zero_done_latency_ok", (d >= 1 && d <= 2), 1);
    chk("zero_activity", {flush_cnt, req_cnt, en_cnt, pop_cnt} != 0, 0);
    next_cyc();

    // abort during a slow write: write finishes, then idle with aborted
    load(32'h3000, 1, 1'b0, 1'b0);
    fifo_q.push_back($urandom); fifo_q.push_back($urandom);
    force_dly = 5;
    clr_counts();
    pulse_start(32'h3000, 3, 1'b0, 1'b0);
    wait_req("abort_wr");
    next_cyc();
    abort = 1'b1;
    next_cyc();
    abort = 1'b0;
    wait_idle("abort_wr");
    chk("abort_wr_aborted", aborted, 1);
    chk("abort_wr_done", done_cnt, 0);
    chk("abort_wr_words", words_done, 1);
    chk("abort_wr_req_cycles", req_cnt, 6);
    chk("abort_wr_pops", pop_cnt, 1);
    chk("abort_wr_exp_left", exp_q.size(), 0);
    force_dly = -1;
    fifo_q.delete();
    next_cyc();

    // overrun: full pulse while waiting on an empty FIFO
    clr_counts();
    pulse_start(32'h4000, 1, 1'b0, 1'b0);
    next_cyc();
    chk("ovr_clear_before", overrun, 0);
    bus.fifo_full = 1'b1;
    next_cyc();
    bus.fifo_full = 1'b0;
    @(negedge clk);
    chk("ovr_set", overrun, 1);
    load(32'h4000, 1, 1'b0, 1'b0);
    wait_idle("ovr");
    chk("ovr_held", overrun, 1);
    chk("ovr_done", done_cnt, 1);
    next_cyc();
    load(32'h4100, 1, 1'b0, 1'b0);
    pulse_start(32'h4100, 1, 1'b0, 1'b0);
    chk("ovr_cleared_by_start", overrun, 0);
    wait_idle("ovr2");
    next_cyc();

    // abort while waiting on an empty FIFO
    clr_counts();
    pulse_start(32'h5000, 2, 1'b1, 1'b0);
    next_cyc();
    abort = 1'b1;
    next_cyc();
    abort = 1'b0;
    wait_idle("abort_wait");
    chk("abort_wait_aborted", aborted, 1);
    chk("abort_wait_done", done_cnt, 0);
    chk("abort_wait_words", words_done, 0);
    next_cyc();
    abort = 1'b1;          // idle abort is a no-op
    next_cyc();
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);

    // reset during a held write request
    load(32'h6000, 4, 1'b0, 1'b0);
    force_dly = 4;
    pulse_start(32'h6000, 4, 1'b0, 1'b0);
    wait_req("rst_wr");
    next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_mid");
    exp_q.delete(); fifo_q.delete();
    force_dly = -1;
    next_cyc();
    run_capture("after_rst", 32'h6000, 2, 1'b0, 1'b0, 1'b0);

    // address wrap, then randomized captures with FIFO gaps
    gap_en = 1'b1;
    run_capture("wrap", 32'hFFFF_FFF8, 4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++)
      run_capture("rand", $urandom, int'($urandom_range(1, 5)), 1'(($urandom_range(0, 1))),
                  1'b0, 1'(($urandom_range(0, 1))));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
